aes128_pipe_encrypt: RTL and testbench
======================================

# aes128_pipe_encrypt

Fully pipelined AES-128 encryption core, FIPS-197 compliant. It accepts one 128-bit plaintext and one 128-bit cipher key on every clock edge and returns the matching ciphertext a fixed 20 edges later, at a throughput of one block per cycle. It is the top-level datapath of the crypto block; there is no handshake and no valid signalling.

## Interface
- No parameters. Key size is fixed at 128 bits and the round count at 10.
- clk  input  1  single clock; all registers update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- state  input  128  plaintext block; bit 127 is byte 0 of the FIPS-197 input (big-endian byte order).
- key  input  128  cipher key, same byte order; may change every cycle.
- out  output  128  ciphertext, registered, same byte order.

## Operation
- The key travels down the pipeline alongside its data. Every block is encrypted with its own key, so back-to-back blocks may use unrelated keys.
- Stage 0 register: s0 = state XOR key, k0 = key.
- Rounds 1..9 each apply SubBytes, ShiftRows, MixColumns and AddRoundKey. Round 10 omits MixColumns.
- Round keys come from standard AES-128 key expansion, with Rcon = 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
- Each round occupies exactly 2 register stages:
  - stage a: key-expansion step registered, together with the S-box/T-table lookup of the state registered;
  - stage b: the combine/XOR with the expanded round key registered.
- Total register depth is 1 + 10×2 = 21, and out is the last register.
- Arithmetic is GF(2^8) with polynomial x^8+x^4+x^3+x+1. There are no other width rules; everything is XOR and table lookup.
- Reset behaviour:
  - While rst is high, every pipeline register, including out, clears to 0 on each rising edge.
  - Reset asserted mid-stream discards all in-flight blocks.
  - Once rst is released, the pipeline runs on the cleared contents. out values before the first post-reset input reaches the output are deterministic but not specified, and are not checked.
- Inputs carry no validity qualifier. Every edge samples a block.

## Timing
- Inputs are sampled on rising edge N. The ciphertext is on out after edge N+20 and stays stable until edge N+21.
- Consecutive inputs on edges N, N+1, N+2, … produce outputs after edges N+20, N+21, N+22, …, one per cycle with no bubbles.
- out is 0 after any edge at which rst is high.
- Inputs must be stable around the rising edge. The bench drives them 2 ns after the falling edge on a 10 ns clock.

## Structure
- Package aes_pkg holds:
  - the 256-entry S-box constant;
  - the Rcon array;
  - the xtime/gmul helper functions;
  - typedefs for a byte, a 32-bit word and a 128-bit block.
- Sub-module aes_round_stage implements one two-stage round, with its paired key-expansion step, and takes parameters for the round's Rcon and a final-round flag.
- The top level instantiates the stage-0 register and 10 aes_round_stage instances.

## Test plan
- FIPS-197 App. B:
  - state=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c;
  - out=3925841d02dc09fbdc118597196a0b32 exactly 20 edges after sampling.
- FIPS-197 App. C.1, on the next edge:
  - state=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f;
  - out=69c4e0d86a7b0430d8cdb78070b4c55a one cycle after the App. B result.
- All-zero, on the next edge: state=0, key=0 → out=66e94bd4ef8a2c3b884cfa59ca342b2e.
- Key LSB only, on the next edge: state=0, key=1 → out=0545aad56da2a97c3663d1432a3d1c84.
- Plaintext LSB only, on the next edge: state=1, key=0 → out=58e2fccefa7e3061367f1d57a4e7455a.
  - This must appear on the 5th consecutive output cycle, confirming one block per cycle with per-block keys.
- Reset mid-stream:
  - hold rst for 3 edges while blocks are in flight → out=0 during reset;
  - no pre-reset ciphertext ever appears afterwards;
  - a new block sampled after release emerges 20 edges later with the correct value.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 definitions.
//   - aes_byte_t / aes_word_t / aes_block_t : byte, 32-bit word, 128-bit block
//   - SBOX  : forward S-box, indexed by the input byte
//   - RCON  : key-expansion round constants for rounds 1..10
//   - xtime, gmul                      : GF(2^8) arithmetic, poly x^8+x^4+x^3+x+1
//   - sub_word, sub_block, shift_rows,
//     mix_columns, key_step            : round building blocks
// Byte order everywhere: bits [127:120] are byte 0 (big-endian), column c is
// bytes 4c..4c+3 and occupies bits [127-32c -: 32].
package aes_pkg;

   typedef logic [7:0]   aes_byte_t;
   typedef logic [31:0]  aes_word_t;
   typedef logic [127:0] aes_block_t;

   localparam int NUM_ROUNDS = 10;

   localparam aes_byte_t SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam aes_byte_t RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Multiply by x modulo the AES polynomial.
   function automatic aes_byte_t xtime(input aes_byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) multiply (shift-and-add); constant operands fold away.
   function automatic aes_byte_t gmul(input aes_byte_t a, input aes_byte_t b);
      aes_byte_t acc;
      aes_byte_t p;
      acc = 8'h00;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         acc = acc ^ (b[i] ? p : 8'h00);
         p   = xtime(p);
      end
      return acc;
   endfunction

   function automatic aes_word_t sub_word(input aes_word_t w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic aes_block_t sub_block(input aes_block_t b);
      aes_block_t r;
      for (int i = 0; i < 16; i++) begin
         r[127-8*i -: 8] = SBOX[b[127-8*i -: 8]];
      end
      return r;
   endfunction

   // Row r of column c takes the byte from column (c+r) mod 4.
   function automatic aes_block_t shift_rows(input aes_block_t b);
      aes_block_t r;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[127-8*(row+4*c) -: 8] = b[127-8*(row+4*((c+row)%4)) -: 8];
         end
      end
      return r;
   endfunction

   function automatic aes_word_t mix_column(input aes_word_t w);
      aes_byte_t a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
              a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
              a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
              gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
   endfunction

   function automatic aes_block_t mix_columns(input aes_block_t b);
      aes_block_t r;
      for (int c = 0; c < 4; c++) begin
         r[127-32*c -: 32] = mix_column(b[127-32*c -: 32]);
      end
      return r;
   endfunction

   // One AES-128 key-expansion step: previous round key -> next round key.
   function automatic aes_block_t key_step(input aes_block_t k, input aes_byte_t rc);
      aes_word_t w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = k;
      t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_round_stage.sv
// aes_round_stage: one AES-128 round spread over two register stages, with the
// matching key-expansion step carried alongside.
//   Parameters: RCON_VAL (round constant), FINAL (1 = skip MixColumns).
//   clk, rst        : clock, synchronous active-high reset
//   s_prev, k_prev  : state and round key from the previous stage
//   s_next, k_next  : registered state and round key after this round
module aes_round_stage
   import aes_pkg::*;
#(
   parameter aes_byte_t RCON_VAL = 8'h01,
   parameter bit        FINAL    = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] s_prev,
   input  logic [127:0] k_prev,
   output logic [127:0] s_next,
   output logic [127:0] k_next
);

   aes_block_t sub_r;     // SubBytes of the incoming state
   aes_block_t rkey_r;    // this round's expanded key
   aes_block_t mixed_s;   // ShiftRows (+ MixColumns) of sub_r

   // Stage a: S-box lookup of the state and key expansion, both registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         sub_r  <= '0;
         rkey_r <= '0;
      end else begin
         sub_r  <= sub_block(s_prev);
         rkey_r <= key_step(k_prev, RCON_VAL);
      end
   end

   // Linear layer; ShiftRows is pure wiring so it shares stage b with the XOR.
   always_comb begin
      mixed_s = shift_rows(sub_r);
      if (!FINAL) begin
         mixed_s = mix_columns(mixed_s);
      end else begin
         mixed_s = mixed_s;
      end
   end

   // Stage b: AddRoundKey registered; the round key moves down with its block.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_next <= '0;
         k_next <= '0;
      end else begin
         s_next <= mixed_s ^ rkey_r;
         k_next <= rkey_r;
      end
   end

endmodule

// File: rtl/aes128_pipe_encrypt.sv
// aes128_pipe_encrypt: fully pipelined AES-128 encryption, one block per cycle,
// every block carrying its own key. Ciphertext appears 20 edges after sampling.
//   clk   : clock, all registers on rising edge
//   rst   : synchronous active-high reset, clears every pipeline register
//   state : 128-bit plaintext, bit 127 = byte 0
//   key   : 128-bit cipher key, same byte order, may change every cycle
//   out   : 128-bit ciphertext, registered (last pipeline register)
module aes128_pipe_encrypt
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] state,
   input  logic [127:0] key,
   output logic [127:0] out
);

   aes_block_t s0_r;
   aes_block_t k0_r;
   aes_block_t s_chain [0:NUM_ROUNDS];
   aes_block_t k_chain [0:NUM_ROUNDS];

   // Stage 0: initial AddRoundKey with the cipher key itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_r <= '0;
         k0_r <= '0;
      end else begin
         s0_r <= state ^ key;
         k0_r <= key;
      end
   end

   assign s_chain[0] = s0_r;
   assign k_chain[0] = k0_r;

   for (genvar i = 0; i < NUM_ROUNDS; i++) begin : g_round
      aes_round_stage #(
         .RCON_VAL (RCON[i+1]),
         .FINAL    (i == NUM_ROUNDS - 1)
      ) u_round (
         .clk    (clk),
         .rst    (rst),
         .s_prev (s_chain[i]),
         .k_prev (k_chain[i]),
         .s_next (s_chain[i+1]),
         .k_next (k_chain[i+1])
      );
   end

   assign out = s_chain[NUM_ROUNDS];

endmodule

// File: tb/tb_aes128_pipe_encrypt.sv
// Self-checking bench for aes128_pipe_encrypt: known-answer vectors on
// consecutive edges, scoreboard keyed by the edge each result is due, plus a
// mid-stream reset sequence.
module tb_aes128_pipe_encrypt;

   logic         clk;
   logic         rst;
   logic [127:0] state;
   logic [127:0] key;
   logic [127:0] out;

   aes128_pipe_encrypt dut (
      .clk   (clk),
      .rst   (rst),
      .state (state),
      .key   (key),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] pt;
      logic [127:0] k;
      logic [127:0] ct;
      string        name;
   } vec_t;

   typedef struct {
      logic [127:0] exp;
      int           due;
      string        name;
   } sb_t;

   vec_t         vecs [5];
   sb_t          sb [$];
   logic [127:0] stale [3];
   int           edge_cnt  = 0;
   int           forbid_lo = 1;
   int           forbid_hi = 0;
   int           tests     = 0;
   int           fails     = 0;
   logic         rst_seen;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @edge %0d: out=%h required=%h", nm, edge_cnt, act, exp);
      end
   endtask

   task automatic check_not(input string nm, input logic [127:0] act, input logic [127:0] bad);
      tests++;
      if (act === bad) begin
         fails++;
         $display("FAIL %s @edge %0d: out=%h must not be discarded block %h", nm, edge_cnt, act, bad);
      end
   endtask

   // Drive one block 2 ns after the falling edge; optionally expect its result.
   task automatic drive(input logic [127:0] pt, input logic [127:0] k,
                        input bit track, input logic [127:0] exp, input string nm);
      @(negedge clk);
      #2;
      state = pt;
      key   = k;
      if (track) sb.push_back('{exp: exp, due: edge_cnt + 21, name: nm});
   endtask

   // Hold zero inputs until the scoreboard and stale window are clear, bounded.
   task automatic wait_drain(input string nm);
      for (int i = 0; i < 60; i++) begin
         if (sb.size() == 0 && edge_cnt > forbid_hi) break;
         @(negedge clk);
      end
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL %s: %0d results never arrived, required 0 pending", nm, sb.size());
         sb.delete();
      end
   endtask

   // Monitor: sample 1 ns after each rising edge.
   always begin
      @(posedge clk);
      edge_cnt = edge_cnt + 1;
      rst_seen = rst;
      #1;
      if (rst_seen) check("reset_out", out, 128'h0);
      if (edge_cnt >= forbid_lo && edge_cnt <= forbid_hi) begin
         for (int j = 0; j < 3; j++) check_not("no_stale", out, stale[j]);
      end
      if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
         check(sb[0].name, out, sb[0].exp);
         void'(sb.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish before 100us");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32, "fips_app_b"};
      vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, "fips_app_c1"};
      vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, "all_zero"};
      vecs[3] = '{128'h0, 128'h1, 128'h0545aad56da2a97c3663d1432a3d1c84, "key_lsb"};
      vecs[4] = '{128'h1, 128'h0, 128'h58e2fccefa7e3061367f1d57a4e7455a, "pt_lsb_5th"};

      // Initial reset: out must read 0 after each reset edge.
      rst   = 1'b1;
      state = 128'h0;
      key   = 128'h0;
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b0;

      // Five blocks on consecutive edges, five results on consecutive edges.
      for (int i = 0; i < 5; i++) begin
         drive(vecs[i].pt, vecs[i].k, 1'b1, vecs[i].ct, vecs[i].name);
      end
      drive(128'h0, 128'h0, 1'b0, 128'h0, "");
      wait_drain("drain_table");

      // Mid-stream reset: three blocks in flight get discarded.
      stale[0] = vecs[0].ct;
      stale[1] = vecs[3].ct;
      stale[2] = vecs[4].ct;
      drive(vecs[0].pt, vecs[0].k, 1'b0, 128'h0, "");
      drive(vecs[3].pt, vecs[3].k, 1'b0, 128'h0, "");
      drive(vecs[4].pt, vecs[4].k, 1'b0, 128'h0, "");
      drive(128'h0, 128'h0, 1'b0, 128'h0, "");
      drive(128'h0, 128'h0, 1'b0, 128'h0, "");
      @(negedge clk);
      #2;
      rst       = 1'b1;
      sb.delete();
      forbid_lo = edge_cnt + 1;
      forbid_hi = edge_cnt + 33;
      repeat (3) @(negedge clk);
      #2;
      rst   = 1'b0;
      state = vecs[1].pt;
      key   = vecs[1].k;
      sb.push_back('{exp: vecs[1].ct, due: edge_cnt + 21, name: "post_reset_c1"});
      drive(128'h0, 128'h0, 1'b0, 128'h0, "");
      wait_drain("drain_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
